bin_input_ctrl: RTL
===================

BIN_INPUT_CTRL -- requirements
Module: bin_input_ctrl

Parameters (name, default, meaning)
REQ-001 The block SHALL have parameter DEBOUNCE_CNT, default 20000: the number of consecutive stable clk cycles (20 ms at 1 MHz) an input must hold before it is accepted.
REQ-002 The block SHALL have parameter HOLD_CNT, default 500000: the number of cycles btn_inc must be held before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_CNT, default 200000: the auto-repeat period in cycles.

Interface (name  direction  width  meaning)
REQ-004 The block SHALL have port clk  input  1  system clock (1 MHz), with all logic on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; reset is asynchronous and active-low.
REQ-006 The block SHALL have port sw  input  8  raw DIP switches, asynchronous and bouncing.
REQ-007 The block SHALL have port btn_load  input  1  raw load push-button, active-high.
REQ-008 The block SHALL have port btn_inc  input  1  raw increment push-button, active-high.
REQ-009 The block SHALL have port bin  output  8  registered binary value that drives the display controller's bin input.
REQ-010 The block SHALL have port bin_valid  output  1  one-cycle pulse asserted on the cycle bin takes a new value.

Function
REQ-011 Each raw input (sw[7:0], btn_load, btn_inc) SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Debounce SHALL treat the synchronized sw as a single 8-bit vector with one shared counter, and each button SHALL have its own counter.
REQ-013 Debounce update rule: if the synchronized value differs from the debounced value, the counter SHALL increment; if it equals the debounced value, the counter SHALL clear.
REQ-014 When the counter reaches DEBOUNCE_CNT-1 while the values still differ, the debounced value SHALL load the synchronized value and the counter SHALL clear.
REQ-015 For the sw vector, any change in the synchronized value while counting SHALL restart the counter from 0.
REQ-016 A glitch shorter than DEBOUNCE_CNT cycles SHALL never change a debounced value.
REQ-017 The load path SHALL act on the debounced btn_load 0->1 edge: on the next cycle, bin SHALL equal debounced sw and bin_valid SHALL be 1.
REQ-018 The increment path SHALL be controlled by an FSM with states IDLE, FIRST, HOLD and REPEAT.
REQ-019 IDLE -> FIRST SHALL occur on the debounced btn_inc rising edge, and bin SHALL increment on the next cycle.
REQ-020 FIRST -> HOLD SHALL occur unconditionally after one cycle, and the hold counter SHALL start.
REQ-021 HOLD -> REPEAT SHALL occur when the hold counter reaches HOLD_CNT-1 with the button still held, and bin SHALL increment on that transition.
REQ-022 In REPEAT, bin SHALL increment every REPEAT_CNT cycles.
REQ-023 From any state, a debounced btn_inc of 0 SHALL return the FSM to IDLE and clear all counters.
REQ-024 Increment SHALL be modulo 256: 8'hFF + 1 = 8'h00, with no carry or flag.
REQ-025 If a load and an increment fall on the same cycle, the load SHALL take priority; the increment is dropped, the FSM proceeds normally, and bin_valid SHALL pulse once.
REQ-026 Changes to sw SHALL NOT alter bin without a load event.
REQ-027 bin_valid SHALL be 1 for exactly one cycle per update, including an update that writes the same value bin already holds.
REQ-028 bin SHALL be glitch-free, driven directly from a register.

Reset
REQ-029 While rst=0, the following SHALL be cleared asynchronously: bin=8'h00, bin_valid=0, all synchronizer and debounced values=0, all counters=0, FSM=IDLE.
REQ-030 A button held through reset release SHALL be seen as a fresh press once debounced.
REQ-031 Asserting reset mid-debounce or mid-repeat SHALL abort the operation without any bin update.

Verification (DEBOUNCE_CNT=4, HOLD_CNT=10, REPEAT_CNT=3)
REQ-032 Reset: with rst=0 held for 3 cycles, then rst=1 -> bin=00 and bin_valid=0 throughout.
REQ-033 Load: set sw=8'h3F stable and pulse btn_load high for 20 cycles -> bin=3F with one bin_valid pulse; then changing sw to 8'h7F without a load leaves bin=3F.
REQ-034 Bounce: btn_load toggles every 2 cycles for 12 cycles, then returns to 0 -> no bin update and no bin_valid pulse.
REQ-035 Wrap: load 8'hFF, then one short btn_inc press -> bin=00 with exactly one bin_valid pulse.
REQ-036 Auto-repeat: hold btn_inc from bin=00 for 30 cycles after debounce -> bin increments at FIRST, at HOLD_CNT, then every 3 cycles; the final count matches the reference model.
REQ-037 Simultaneous press and mid-reset: debounced btn_load and btn_inc rise on the same cycle with sw=8'hBF -> bin=BF; asserting rst during REPEAT -> bin=00 immediately.

Source files
------------

// File: rtl/bin_input_ctrl.sv
// Front-panel input controller: synchronizes and debounces DIP switches and
// two push-buttons, then drives a registered 8-bit value with load/auto-repeat.
module bin_input_ctrl #(
    parameter int DEBOUNCE_CNT = 20000,
    parameter int HOLD_CNT     = 500000,
    parameter int REPEAT_CNT   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_inc,
    output logic [7:0] bin,
    output logic       bin_valid
);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam int HW = $clog2(HOLD_CNT + 1);
    localparam int RW = $clog2(REPEAT_CNT + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CNT - 1);
    localparam logic [DW-1:0] DB_ONE = DW'(1);
    localparam logic [HW-1:0] HL_MAX = HW'(HOLD_CNT - 1);
    localparam logic [HW-1:0] HL_ONE = HW'(1);
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_CNT - 1);
    localparam logic [RW-1:0] RP_ONE = RW'(1);

    typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;

    logic [7:0]    r_sw_s1, r_sw_s2, r_sw_last, r_sw_db;
    logic          r_ld_s1, r_ld_s2, r_ld_db, r_ld_q;
    logic          r_inc_s1, r_inc_s2, r_inc_db, r_inc_q;
    logic [DW-1:0] r_sw_cnt, r_ld_cnt, r_inc_cnt;
    logic [HW-1:0] r_hold_cnt, w_hold_nxt;
    logic [RW-1:0] r_rep_cnt, w_rep_nxt;
    state_t        r_state, w_next;
    logic          w_inc, w_ld_rise, w_inc_rise;
    logic [7:0]    r_bin;
    logic          r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_ld_s1  <= 1'b0;
            r_ld_s2  <= 1'b0;
            r_inc_s1 <= 1'b0;
            r_inc_s2 <= 1'b0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_ld_s1  <= btn_load;
            r_ld_s2  <= r_ld_s1;
            r_inc_s1 <= btn_inc;
            r_inc_s2 <= r_inc_s1;
        end
    end

    // A new switch pattern mid-count restarts the stability window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_last <= '0;
            r_sw_db   <= '0;
            r_sw_cnt  <= '0;
        end else begin
            r_sw_last <= r_sw_s2;
            if (r_sw_s2 == r_sw_db) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt != '0 && r_sw_s2 != r_sw_last) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt == DB_MAX) begin
                r_sw_db  <= r_sw_s2;
                r_sw_cnt <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + DB_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_db   <= 1'b0;
            r_ld_cnt  <= '0;
            r_ld_q    <= 1'b0;
            r_inc_db  <= 1'b0;
            r_inc_cnt <= '0;
            r_inc_q   <= 1'b0;
        end else begin
            r_ld_q  <= r_ld_db;
            r_inc_q <= r_inc_db;
            if (r_ld_s2 == r_ld_db) begin
                r_ld_cnt <= '0;
            end else if (r_ld_cnt == DB_MAX) begin
                r_ld_db  <= r_ld_s2;
                r_ld_cnt <= '0;
            end else begin
                r_ld_cnt <= r_ld_cnt + DB_ONE;
            end
            if (r_inc_s2 == r_inc_db) begin
                r_inc_cnt <= '0;
            end else if (r_inc_cnt == DB_MAX) begin
                r_inc_db  <= r_inc_s2;
                r_inc_cnt <= '0;
            end else begin
                r_inc_cnt <= r_inc_cnt + DB_ONE;
            end
        end
    end

    assign w_ld_rise  = r_ld_db & ~r_ld_q;
    assign w_inc_rise = r_inc_db & ~r_inc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_inc      = 1'b0;
        w_hold_nxt = r_hold_cnt;
        w_rep_nxt  = r_rep_cnt;
        if (!r_inc_db) begin
            w_next     = IDLE;
            w_hold_nxt = '0;
            w_rep_nxt  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_inc_rise) begin
                        w_next = FIRST;
                        w_inc  = 1'b1;
                    end
                end
                FIRST: begin
                    w_next     = HOLD;
                    w_hold_nxt = '0;
                end
                HOLD: begin
                    if (r_hold_cnt == HL_MAX) begin
                        w_next     = REPEAT;
                        w_inc      = 1'b1;
                        w_hold_nxt = '0;
                        w_rep_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HL_ONE;
                    end
                end
                REPEAT: begin
                    if (r_rep_cnt == RP_MAX) begin
                        w_inc     = 1'b1;
                        w_rep_nxt = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + RP_ONE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Load wins over a coincident increment; the FSM still advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin   <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_ld_rise | w_inc;
            if (w_ld_rise) begin
                r_bin <= r_sw_db;
            end else if (w_inc) begin
                r_bin <= r_bin + 8'd1;
            end
        end
    end

    assign bin       = r_bin;
    assign bin_valid = r_valid;
endmodule
